// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues in-order fetches under a credit rule, queues
// responses in a circular buffer and squashes in-flight work on a redirect.
module prefetch_unit #(
  parameter int unsigned    WORD      = 64,
  parameter int unsigned    INSTR_LEN = 32,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 instr_valid,
  output logic [INSTR_LEN-1:0] instr,
  output logic [WORD-1:0]      instr_pc,
  input  logic                 instr_ready
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;
  // Stale requests can pile up across back-to-back redirects, so give them headroom.
  localparam int unsigned DISC_W = CNT_W + 4;

  logic [WORD-1:0]      fetch_pc;
  logic [WORD-1:0]      resp_pc;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     outstanding;
  logic [DISC_W-1:0]    discard;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [INSTR_LEN-1:0] q_instr [DEPTH];
  logic [WORD-1:0]      q_pc    [DEPTH];

  logic                 fire;
  logic                 keep;
  logic                 drop;
  logic                 pop;
  logic                 credit;
  logic [OCC_W-1:0]     occupancy;
  logic [WORD-1:0]      target_aligned;
  logic [DISC_W-1:0]    disc_base;

  // Credit: every issued, kept request already owns a queue slot.
  assign occupancy = OCC_W'(count) + OCC_W'(outstanding);
  assign credit    = occupancy < OCC_W'(DEPTH);

  assign imem_req  = !reset && !pc_src && credit;
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_gnt;

  assign drop      = imem_rvalid && (discard != '0);
  assign keep      = imem_rvalid && (discard == '0) && (outstanding != '0);
  assign pop       = instr_valid && instr_ready && !pc_src;

  assign instr_valid = !reset && (count != '0);
  assign instr       = q_instr[head];
  assign instr_pc    = q_pc[head];

  assign target_aligned = branch_target & ~WORD'(3);
  assign disc_base      = discard - DISC_W'(drop);

  // Control state: PCs, occupancy, credit and squash accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (pc_src) begin
      // A response kept this cycle is squashed too, so it leaves the books entirely.
      fetch_pc    <= target_aligned;
      resp_pc     <= target_aligned;
      count       <= '0;
      outstanding <= '0;
      discard     <= disc_base + DISC_W'(outstanding) - DISC_W'(keep);
      head        <= '0;
      tail        <= '0;
    end else begin
      if (fire) begin
        fetch_pc <= fetch_pc + WORD'(4);
      end
      if (keep) begin
        resp_pc <= resp_pc + WORD'(4);
        tail    <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(keep);
      count       <= count + CNT_W'(keep) - CNT_W'(pop);
      discard     <= disc_base;
    end
  end

  // Queue storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (keep && !pc_src) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus random traffic
// against an epoch-tagged request/instruction-stream reference model.
module tb_prefetch_unit;

  localparam int unsigned WORD      = 64;
  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned DEPTH     = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 pc_src;
  logic [WORD-1:0]      branch_target;
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [INSTR_LEN-1:0] imem_rdata;
  logic                 instr_valid;
  logic [INSTR_LEN-1:0] instr;
  logic [WORD-1:0]      instr_pc;
  logic                 instr_ready;

  prefetch_unit #(.WORD(WORD), .INSTR_LEN(INSTR_LEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int epoch; int due; } pend_t;
  typedef struct { logic [31:0] data; logic [63:0] pc; } exp_t;

  pend_t       pend[$];   // requests in flight at the memory, oldest first
  exp_t        q[$];      // instructions the consumer should see, in order
  int          epoch_cur  = 0;
  logic [63:0] model_fetch = 64'h0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          grant_obs = 0;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  function automatic int kept_inflight();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch_cur) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model for the coming edge.
  task automatic step(input bit src, input logic [63:0] tgt, input bit gnt,
                      input bit rdy, input bit allow_rsp);
    bit    rsp;
    bit    exp_req;
    pend_t p;
    pend_t np;
    exp_t  e;
    @(negedge clk);
    rsp           = allow_rsp && pend.size() != 0 && pend[0].due <= cyc;
    pc_src        = src;
    branch_target = tgt;
    imem_gnt      = gnt;
    instr_ready   = rdy;
    imem_rvalid   = rsp;
    imem_rdata    = rsp ? mem_word(pend[0].addr) : $urandom;
    #1;
    exp_req = !src && (q.size() + kept_inflight() < DEPTH);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, model_fetch);
    check("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr", 64'(instr), 64'(q[0].data));
      check("instr_pc", instr_pc, q[0].pc);
    end
    if (imem_req && gnt) grant_obs++;
    if (rsp) p = pend.pop_front();
    if (src) begin
      epoch_cur++;
      q.delete();
      model_fetch = tgt & ~64'h3;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (rsp && p.epoch == epoch_cur) begin
        e.data = mem_word(p.addr);
        e.pc   = p.addr;
        q.push_back(e);
      end
      if (exp_req && gnt) begin
        np.addr  = model_fetch;
        np.epoch = epoch_cur;
        np.due   = cyc + int'($urandom_range(lat_max, lat_min));
        pend.push_back(np);
        model_fetch = model_fetch + 64'd4;
      end
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    pc_src = 1'b0; branch_target = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, 64'(imem_req), 64'd0);
    check({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_instr"}, 64'(instr), 64'd0);
    check({tag, "_instr_pc"}, instr_pc, 64'd0);
  endtask

  initial begin
    logic [63:0] tgt;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    check_reset_outputs("por");
    @(negedge clk); cyc++;
    reset = 1'b0;

    // Consumer stalled: exactly DEPTH grants, then drain in order and resume at 0x10.
    lat_min = 1; lat_max = 1; grant_obs = 0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("grants_while_stalled", 64'(grant_obs), 64'(DEPTH));
    @(posedge clk); #1;
    check("req_when_full", 64'(imem_req), 64'd0);
    check("full_head_pc", instr_pc, 64'h0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Restart at 0 and stream with 1-cycle memory: one instruction per cycle.
    step(1'b1, 64'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Three requests outstanding at latency 3, then redirect to an unaligned target.
    step(1'b1, 64'h200, 1'b1, 1'b1, 1'b1);
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 64'h1003, 1'b1, 1'b1, 1'b0);
    lat_min = 1; lat_max = 1;
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Redirect coincident with a kept response and a ready consumer.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 64'h2000, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("valid_after_coincident", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Random traffic, including targets just below the top of the address space.
    for (int i = 0; i < 1500; i++) begin
      lat_min = 1; lat_max = 3;
      tgt = ($urandom_range(3, 0) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0)))
                                       : {$urandom, $urandom};
      step($urandom_range(19, 0) == 0, tgt, $urandom_range(9, 0) < 7,
           $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 8);
    end

    // Reset mid-stream with two requests outstanding.
    lat_min = 2; lat_max = 2;
    step(1'b1, 64'h3000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    imem_rvalid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    epoch_cur++;
    q.delete();
    model_fetch = 64'h0;
    cyc++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_rvalid = pend.size() != 0 && pend[0].due <= cyc;
      imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : 32'h0;
      if (imem_rvalid) void'(pend.pop_front());
      #1;
      check_reset_outputs("in_reset");
      cyc++;
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    cyc++;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
